// File: rtl/xadc_pkg.sv
// Shared XADC definitions: DRP channel addresses, widths and controller state encodings.
package xadc_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;
    localparam int SAMPLE_W   = 12;

    localparam logic [DRP_ADDR_W-1:0] VAUX4_ADDR  = 7'h14;
    localparam logic [DRP_ADDR_W-1:0] VAUX12_ADDR = 7'h1C;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_A = 3'd1,
        ST_WAIT_A  = 3'd2,
        ST_ISSUE_B = 3'd3,
        ST_WAIT_B  = 3'd4,
        ST_PRESENT = 3'd5
    } xadc_drp_reader_state_t;

    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_ISSUE = 2'd1,
        PORT_WAIT  = 2'd2
    } drp_port_state_t;

endpackage

// File: rtl/xadc_drp_reader_drp_read_port.sv
// Single DRP read: start -> one-cycle den -> wait for drdy with a timeout -> done/timeout + data.
//
// state      | meaning
// PORT_IDLE  | no read in flight, drdy ignored
// PORT_ISSUE | den high for this cycle only
// PORT_WAIT  | sampling drdy, timeout down-counter running
module drp_read_port
    import xadc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DRP_ADDR_W-1:0] addr_i,
    output logic                  den_o,
    output logic [DRP_ADDR_W-1:0] daddr_o,
    input  logic                  drdy_i,
    input  logic [DRP_DATA_W-1:0] do_i,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [SAMPLE_W-1:0]   data_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    drp_port_state_t       state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DRP_ADDR_W-1:0] addr_q, addr_d;
    logic                  unused_do_lsbs;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PORT_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Counter loads on the den cycle so the last wait cycle is TIMEOUT_CYCLES after den.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        done_o    = 1'b0;
        timeout_o = 1'b0;
        case (state_q)
            PORT_IDLE: state_d = PORT_IDLE;
            PORT_ISSUE: begin
                state_d = PORT_WAIT;
                cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
            end
            PORT_WAIT: begin
                if (drdy_i) begin
                    done_o  = 1'b1;
                    state_d = PORT_IDLE;
                end else if (cnt_q == '0) begin
                    timeout_o = 1'b1;
                    state_d   = PORT_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = PORT_IDLE;
        endcase
        if (start_i) begin
            state_d = PORT_ISSUE;
            addr_d  = addr_i;
        end
    end

    assign den_o          = (state_q == PORT_ISSUE);
    assign daddr_o        = addr_q;
    assign data_o         = do_i[DRP_DATA_W-1:DRP_DATA_W-SAMPLE_W];
    assign unused_do_lsbs = ^do_i[DRP_DATA_W-SAMPLE_W-1:0];

endmodule

// File: rtl/xadc_drp_reader.sv
// Drains two XADC channels over DRP after each end-of-sequence and presents them as a sample pair.
//
// state      | meaning
// ST_IDLE    | waiting for eos
// ST_ISSUE_A | den pulse for channel A read
// ST_WAIT_A  | waiting for channel A drdy or timeout
// ST_ISSUE_B | den pulse for channel B read
// ST_WAIT_B  | waiting for channel B drdy or timeout
// ST_PRESENT | sample pair valid, waiting for ready
module xadc_drp_reader
    import xadc_pkg::*;
#(
    parameter logic [DRP_ADDR_W-1:0] CH_A_ADDR      = VAUX4_ADDR,
    parameter logic [DRP_ADDR_W-1:0] CH_B_ADDR      = VAUX12_ADDR,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                  dclk_in,
    input  logic                  reset_in,
    input  logic                  eos_in,
    output logic [DRP_ADDR_W-1:0] daddr_out,
    output logic                  den_out,
    output logic                  dwe_out,
    output logic [DRP_DATA_W-1:0] di_out,
    input  logic                  drdy_in,
    input  logic [DRP_DATA_W-1:0] do_in,
    output logic [SAMPLE_W-1:0]   sample_a_out,
    output logic [SAMPLE_W-1:0]   sample_b_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [7:0]            overrun_count_out,
    output logic                  timeout_err_out
);

    xadc_drp_reader_state_t state_q, state_d;
    logic [SAMPLE_W-1:0]    sample_a_q, sample_a_d;
    logic [SAMPLE_W-1:0]    sample_b_q, sample_b_d;
    logic [7:0]             overrun_q, overrun_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   rd_start;
    logic [DRP_ADDR_W-1:0]  rd_addr;
    logic                   rd_done;
    logic                   rd_timeout;
    logic [SAMPLE_W-1:0]    rd_data;
    logic                   eos_taken;

    drp_read_port #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_read_port (
        .clk_i    (dclk_in),
        .rst_i    (reset_in),
        .start_i  (rd_start),
        .addr_i   (rd_addr),
        .den_o    (den_out),
        .daddr_o  (daddr_out),
        .drdy_i   (drdy_in),
        .do_i     (do_in),
        .done_o   (rd_done),
        .timeout_o(rd_timeout),
        .data_o   (rd_data)
    );

    always_ff @(posedge dclk_in) begin
        if (reset_in) begin
            state_q       <= ST_IDLE;
            sample_a_q    <= '0;
            sample_b_q    <= '0;
            overrun_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_a_q    <= sample_a_d;
            sample_b_q    <= sample_b_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sample_a_d    = sample_a_q;
        sample_b_d    = sample_b_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        rd_start      = 1'b0;
        rd_addr       = CH_A_ADDR;
        eos_taken     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (eos_in) begin
                    eos_taken = 1'b1;
                    rd_start  = 1'b1;
                    state_d   = ST_ISSUE_A;
                end
            end
            ST_ISSUE_A: state_d = ST_WAIT_A;
            ST_WAIT_A: begin
                if (rd_done) begin
                    sample_a_d = rd_data;
                    rd_start   = 1'b1;
                    rd_addr    = CH_B_ADDR;
                    state_d    = ST_ISSUE_B;
                end else if (rd_timeout) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_ISSUE_B: state_d = ST_WAIT_B;
            ST_WAIT_B: begin
                if (rd_done) begin
                    sample_b_d = rd_data;
                    state_d    = ST_PRESENT;
                end else if (rd_timeout) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                // An eos landing on the handshake cycle starts the next pair straight away.
                if (ready_in) begin
                    if (eos_in) begin
                        eos_taken = 1'b1;
                        rd_start  = 1'b1;
                        state_d   = ST_ISSUE_A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (eos_in && !eos_taken && overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    assign dwe_out           = 1'b0;
    assign di_out            = '0;
    assign sample_a_out      = sample_a_q;
    assign sample_b_out      = sample_b_q;
    assign valid_out         = (state_q == ST_PRESENT);
    assign overrun_count_out = overrun_q;
    assign timeout_err_out   = timeout_err_q;

endmodule
